ram_seq_ctrl: RTL and testbench

RAM_SEQ_CTRL -- requirements
Module: ram_seq_ctrl

---
 rtl/ram_seq_ctrl_pkg.sv | 22 ++
 rtl/ram_seq_csum.sv | 30 +++
 rtl/ram_seq_ctrl.sv | 169 ++++++++++++++++
 tb/tb_ram_seq_ctrl.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_seq_ctrl_pkg.sv
// Shared definitions for the RAM sequence controller: state encoding, width defaults, frame limit.
// Build option RAM_SEQ_CTRL_CHECKSUM_EN adds the write/readback checksum outputs.
package ram_seq_ctrl_pkg;

   localparam int unsigned ADDR_W_DEF = 6;
   localparam int unsigned DATA_W_DEF = 8;
   localparam int unsigned MAX_LEN    = 64;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      FILL   = 3'd1,
      RD_REQ = 3'd2,
      RD_CAP = 3'd3,
      RD_OUT = 3'd4,
      DONE   = 3'd5
   } state_t;

   function automatic logic len_legal(input int unsigned len_v, input int unsigned max_len);
      return (len_v != 0) && (len_v <= max_len);
   endfunction

endpackage

// File: rtl/ram_seq_csum.sv
// Modulo-2^DATA_W byte accumulator, cleared synchronously by i_clr or asynchronously by rst.
// Only instantiated when RAM_SEQ_CTRL_CHECKSUM_EN is defined.
module ram_seq_csum
   import ram_seq_ctrl_pkg::*;
#(
   parameter int unsigned DATA_W = DATA_W_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_clr,
   input  logic              i_en,
   input  logic [DATA_W-1:0] i_data,
   output logic [DATA_W-1:0] o_sum
);

   logic [DATA_W-1:0] r_sum;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_sum <= '0;
      end else if (i_clr) begin
         r_sum <= '0;
      end else if (i_en) begin
         r_sum <= r_sum + i_data;
      end
   end

   assign o_sum = r_sum;

endmodule

// File: rtl/ram_seq_ctrl.sv
// Frame controller: fills an external RAM with len bytes, then reads them back in order.
// Defining RAM_SEQ_CTRL_CHECKSUM_EN adds csum/csum_err comparing written and captured sums.
module ram_seq_ctrl
   import ram_seq_ctrl_pkg::*;
#(
   parameter int unsigned ADDR_W = ADDR_W_DEF,
   parameter int unsigned DATA_W = DATA_W_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [ADDR_W:0]   len,
   input  logic              wr_valid,
   output logic              wr_ready,
   input  logic [DATA_W-1:0] wr_data,
   output logic              rd_valid,
   input  logic              rd_ready,
   output logic [DATA_W-1:0] rd_data,
   output logic              busy,
   output logic              done,
   output logic              ram_cs,
   output logic              ram_wr,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [DATA_W-1:0] ram_din,
   input  logic [DATA_W-1:0] ram_dout
`ifdef RAM_SEQ_CTRL_CHECKSUM_EN
   ,
   output logic [DATA_W-1:0] csum,
   output logic              csum_err
`endif
);

   localparam int unsigned     MaxLen = 1 << ADDR_W;
   localparam logic [ADDR_W:0] LenOne = 1;
   localparam logic [ADDR_W-1:0] PtrOne = 1;

   state_t            r_state;
   logic [ADDR_W:0]   r_len;
   logic [ADDR_W-1:0] r_wr_ptr;
   logic [ADDR_W-1:0] r_rd_ptr;
   logic [DATA_W-1:0] r_rd_data;
   logic              r_busy;
   logic              r_done;
   logic              r_wr_ready;
   logic              r_rd_valid;

   logic w_accept;
   logic w_wr_fire;
   logic w_rd_req;
   logic w_wr_last;
   logic w_rd_last;

   assign w_accept  = (r_state == IDLE) && start && len_legal(32'(len), MaxLen);
   assign w_wr_fire = (r_state == FILL) && r_wr_ready && wr_valid;
   assign w_rd_req  = (r_state == RD_REQ);
   // Compare at ADDR_W+1 bits so len=64 ends on pointer 63 without wrapping.
   assign w_wr_last = ({1'b0, r_wr_ptr} == (r_len - LenOne));
   assign w_rd_last = ({1'b0, r_rd_ptr} == (r_len - LenOne));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= IDLE;
         r_len      <= '0;
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_rd_data  <= '0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
         r_wr_ready <= 1'b0;
         r_rd_valid <= 1'b0;
      end else begin
         r_done <= 1'b0;
         unique case (r_state)
            IDLE: begin
               if (w_accept) begin
                  r_len      <= len;
                  r_wr_ptr   <= '0;
                  r_rd_ptr   <= '0;
                  r_busy     <= 1'b1;
                  r_wr_ready <= 1'b1;
                  r_state    <= FILL;
               end
            end
            FILL: begin
               if (w_wr_fire) begin
                  r_wr_ptr <= r_wr_ptr + PtrOne;
                  if (w_wr_last) begin
                     r_wr_ready <= 1'b0;
                     r_state    <= RD_REQ;
                  end
               end
            end
            RD_REQ: begin
               r_state <= RD_CAP;
            end
            RD_CAP: begin
               r_rd_data  <= ram_dout;
               r_rd_valid <= 1'b1;
               r_state    <= RD_OUT;
            end
            RD_OUT: begin
               if (rd_ready) begin
                  r_rd_valid <= 1'b0;
                  if (w_rd_last) begin
                     r_done  <= 1'b1;
                     r_state <= DONE;
                  end else begin
                     r_rd_ptr <= r_rd_ptr + PtrOne;
                     r_state  <= RD_REQ;
                  end
               end
            end
            DONE: begin
               r_busy  <= 1'b0;
               r_state <= IDLE;
            end
            default: begin
               r_busy     <= 1'b0;
               r_wr_ready <= 1'b0;
               r_rd_valid <= 1'b0;
               r_state    <= IDLE;
            end
         endcase
      end
   end

   assign wr_ready = r_wr_ready;
   assign rd_valid = r_rd_valid;
   assign rd_data  = r_rd_data;
   assign busy     = r_busy;
   assign done     = r_done;

   // RAM bus is zeroed whenever it is not actively writing or reading.
   assign ram_cs   = w_wr_fire || w_rd_req;
   assign ram_wr   = w_wr_fire;
   assign ram_addr = w_wr_fire ? r_wr_ptr : (w_rd_req ? r_rd_ptr : '0);
   assign ram_din  = w_wr_fire ? wr_data : '0;

`ifdef RAM_SEQ_CTRL_CHECKSUM_EN
   logic [DATA_W-1:0] w_sum_wr;
   logic [DATA_W-1:0] w_sum_rd;

   ram_seq_csum #(
      .DATA_W(DATA_W)
   ) u_csum_wr (
      .clk   (clk),
      .rst   (rst),
      .i_clr (w_accept),
      .i_en  (w_wr_fire),
      .i_data(wr_data),
      .o_sum (w_sum_wr)
   );

   ram_seq_csum #(
      .DATA_W(DATA_W)
   ) u_csum_rd (
      .clk   (clk),
      .rst   (rst),
      .i_clr (w_accept),
      .i_en  (r_state == RD_CAP),
      .i_data(ram_dout),
      .o_sum (w_sum_rd)
   );

   assign csum     = w_sum_wr;
   assign csum_err = r_done && (w_sum_wr != w_sum_rd);
`endif

endmodule

// File: tb/tb_ram_seq_ctrl.sv
// Scoreboard bench for ram_seq_ctrl with a 64x8 registered-read RAM model.
// Checksum checks are compiled in when RAM_SEQ_CTRL_CHECKSUM_EN is defined.
module tb_ram_seq_ctrl;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start = 1'b0;
   logic [6:0] len = '0;
   logic       wr_valid = 1'b0;
   logic       wr_ready;
   logic [7:0] wr_data = '0;
   logic       rd_valid;
   logic       rd_ready = 1'b1;
   logic [7:0] rd_data;
   logic       busy;
   logic       done;
   logic       ram_cs;
   logic       ram_wr;
   logic [5:0] ram_addr;
   logic [7:0] ram_din;
   logic [7:0] ram_dout;
`ifdef RAM_SEQ_CTRL_CHECKSUM_EN
   logic [7:0] csum;
   logic       csum_err;
`endif

   logic [7:0] mem [64];
   logic [7:0] ram_q = '0;
   logic       corrupt = 1'b0;
   logic [7:0] frame_bytes [64];

   assign ram_dout = ram_q ^ {7'd0, corrupt};

   ram_seq_ctrl dut (
      .clk     (clk),
      .rst     (rst),
      .start   (start),
      .len     (len),
      .wr_valid(wr_valid),
      .wr_ready(wr_ready),
      .wr_data (wr_data),
      .rd_valid(rd_valid),
      .rd_ready(rd_ready),
      .rd_data (rd_data),
      .busy    (busy),
      .done    (done),
      .ram_cs  (ram_cs),
      .ram_wr  (ram_wr),
      .ram_addr(ram_addr),
      .ram_din (ram_din),
      .ram_dout(ram_dout)
`ifdef RAM_SEQ_CTRL_CHECKSUM_EN
      ,
      .csum    (csum),
      .csum_err(csum_err)
`endif
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (ram_cs) begin
         if (ram_wr) mem[ram_addr] <= ram_din;
         else        ram_q <= mem[ram_addr];
      end
   end

   int n_checks = 0;
   int n_errors = 0;

   typedef struct packed {
      logic [5:0] addr;
      logic [7:0] data;
   } wr_t;

   wr_t        wr_q[$];
   logic [5:0] rd_addr_q[$];
   logic [7:0] rd_q[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic check_zero(input string name);
      check(name, {4'd0, busy, done, wr_ready, rd_valid, rd_data, ram_cs, ram_wr, ram_addr, ram_din},
            32'd0);
   endtask

   // Monitor: RAM bus protocol, write/read address order, readback data.
   always @(negedge clk) begin
      wr_t e;
      if (!ram_cs) check("ram_idle_zero", {ram_wr, ram_addr, ram_din}, 32'd0);
      if (ram_cs && ram_wr) begin
         if (wr_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL unexpected_write: addr %0d data 0x%0h, expected no write", ram_addr,
                     ram_din);
         end else begin
            e = wr_q.pop_front();
            check("wr_addr", ram_addr, e.addr);
            check("wr_data", ram_din, e.data);
         end
      end
      if (ram_cs && !ram_wr) begin
         if (rd_addr_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL unexpected_read: addr %0d, expected no read", ram_addr);
         end else begin
            check("rd_addr", ram_addr, rd_addr_q.pop_front());
         end
      end
      if (rd_valid && rd_ready) begin
         if (rd_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL unexpected_rd: data 0x%0h, expected no output", rd_data);
         end else begin
            check("rd_data", rd_data, rd_q.pop_front());
         end
      end
   end

   task automatic write_bytes(input int n, output logic ok);
      int cnt;
      ok = 1'b1;
      for (int i = 0; i < n; i++) begin
         wr_valid = 1'b1;
         wr_data  = frame_bytes[i];
         cnt = 0;
         @(negedge clk);
         while (!wr_ready && cnt < 20) begin
            @(negedge clk);
            cnt++;
         end
         if (!wr_ready) begin
            check("wr_ready_timeout", wr_ready, 1);
            wr_valid = 1'b0;
            ok = 1'b0;
            return;
         end
         @(posedge clk);
         #1;
      end
      wr_valid = 1'b0;
   endtask

   task automatic run_frame(input int n, input logic [7:0] mask, input int stall_idx);
      int         cnt;
      logic       ok;
      logic [7:0] sum;
      sum = '0;
      for (int i = 0; i < n; i++) begin
         wr_q.push_back({i[5:0], frame_bytes[i]});
         rd_addr_q.push_back(i[5:0]);
         rd_q.push_back(frame_bytes[i] ^ mask);
         sum = sum + frame_bytes[i];
      end
      @(posedge clk);
      #1;
      start = 1'b1;
      len   = n[6:0];
      @(posedge clk);
      #1;
      start = 1'b0;
      check("busy_after_start", busy, 1);
      check("wr_ready_in_fill", wr_ready, 1);
      write_bytes(n, ok);
      if (!ok) return;
      for (int k = 0; k < n; k++) begin
         cnt = 0;
         while (!rd_valid && cnt < 20) begin
            @(posedge clk);
            #1;
            cnt++;
         end
         if (!rd_valid) begin
            check("rd_valid_timeout", rd_valid, 1);
            return;
         end
         check("rd_rate", (cnt <= 2), 1);
         if (k == stall_idx) begin
            rd_ready = 1'b0;
            repeat (10) begin
               @(posedge clk);
               #1;
               check("stall_rd_data", rd_data, frame_bytes[k] ^ mask);
               check("stall_rd_valid", rd_valid, 1);
               check("stall_ram_cs", ram_cs, 0);
            end
            rd_ready = 1'b1;
         end
         @(posedge clk);
         #1;
      end
      check("done_pulse", done, 1);
      check("busy_in_done", busy, 1);
`ifdef RAM_SEQ_CTRL_CHECKSUM_EN
      check("csum", csum, sum);
      check("csum_err", csum_err, (mask != 8'd0));
`endif
      @(posedge clk);
      #1;
      check("done_cleared", done, 0);
      check("busy_after_done", busy, 0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation still running, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      logic ok;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_zero("reset_outputs");
      @(posedge clk);
      #1;
      rst = 1'b0;

      // Basic 4-byte frame.
      frame_bytes[0] = 8'h11;
      frame_bytes[1] = 8'h22;
      frame_bytes[2] = 8'h33;
      frame_bytes[3] = 8'h44;
      run_frame(4, 8'h00, -1);

      // Illegal lengths, with stray wr_valid outside FILL.
      for (int v = 0; v < 2; v++) begin
         @(posedge clk);
         #1;
         start    = 1'b1;
         len      = (v == 0) ? 7'd0 : 7'd65;
         wr_valid = 1'b1;
         wr_data  = 8'hEE;
         @(posedge clk);
         #1;
         start = 1'b0;
         repeat (3) begin
            check("illegal_len_busy", busy, 0);
            check("illegal_len_ram_cs", ram_cs, 0);
            check("illegal_len_wr_ready", wr_ready, 0);
            @(posedge clk);
            #1;
         end
         wr_valid = 1'b0;
      end

      // Full 64-byte frame.
      for (int i = 0; i < 64; i++) frame_bytes[i] = i[7:0];
      run_frame(64, 8'h00, -1);

      // Readback stall on the second byte.
      frame_bytes[0] = 8'hA1;
      frame_bytes[1] = 8'hB2;
      frame_bytes[2] = 8'hC3;
      run_frame(3, 8'h00, 1);

      // Reset after 2 of 5 bytes.
      frame_bytes[0] = 8'h01;
      frame_bytes[1] = 8'h02;
      frame_bytes[2] = 8'h03;
      wr_q.push_back({6'd0, 8'h01});
      wr_q.push_back({6'd1, 8'h02});
      @(posedge clk);
      #1;
      start = 1'b1;
      len   = 7'd5;
      @(posedge clk);
      #1;
      start = 1'b0;
      write_bytes(2, ok);
      wr_valid = 1'b1;
      wr_data  = 8'h03;
      rst      = 1'b1;
      #1;
      check_zero("reset_midframe");
      wr_valid = 1'b0;
      check("reset_write_count", wr_q.size(), 0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      frame_bytes[0] = 8'h5A;
      frame_bytes[1] = 8'hA5;
      run_frame(2, 8'h00, -1);

`ifdef RAM_SEQ_CTRL_CHECKSUM_EN
      frame_bytes[0] = 8'hFF;
      frame_bytes[1] = 8'h02;
      run_frame(2, 8'h00, -1);
      corrupt = 1'b1;
      frame_bytes[0] = 8'h10;
      frame_bytes[1] = 8'h20;
      frame_bytes[2] = 8'h30;
      run_frame(3, 8'h01, -1);
      corrupt = 1'b0;
`endif

      repeat (2) @(posedge clk);
      #1;
      check("wr_q_drained", wr_q.size(), 0);
      check("rd_addr_q_drained", rd_addr_q.size(), 0);
      check("rd_q_drained", rd_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
